// File: rtl/iir_pkg.sv
// Shared widths, coefficient address map, FSM state type and the
// round/saturate helper for the biquad filter.
package iir_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC   = 14;
  localparam int unsigned ACC_W  = 36;
  localparam int unsigned N_TAPS = 5;

  // Coefficient addresses; also used as the MAC tap index order.
  localparam logic [2:0] ADDR_B0 = 3'd0;
  localparam logic [2:0] ADDR_B1 = 3'd1;
  localparam logic [2:0] ADDR_B2 = 3'd2;
  localparam logic [2:0] ADDR_A1 = 3'd3;
  localparam logic [2:0] ADDR_A2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] y;
    logic                     sat;
  } y_res_t;

  // 1.0 in Q2.14; a bank holding only b0=UNITY is a passthrough.
  localparam coef_t UNITY = 16'sh4000;
  localparam coef_t RST_BANK [N_TAPS] = '{UNITY, '0, '0, '0, '0};

  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-DATA_W){1'b1}}, 1'b1, {(DATA_W-1){1'b0}}};

  // Round half up, drop the fraction bits, clip to the 16-bit range.
  function automatic y_res_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    y_res_t                  res;
    r = (acc + ROUND_HALF) >>> FRAC;
    if (r > Y_MAX) begin
      res.y   = Y_MAX[DATA_W-1:0];
      res.sat = 1'b1;
    end else if (r < Y_MIN) begin
      res.y   = Y_MIN[DATA_W-1:0];
      res.sat = 1'b1;
    end else begin
      res.y   = r[DATA_W-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared 16x16 signed multiplier feeding a 36-bit add/subtract accumulator.
module iir_mac
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [COEF_W+DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [ACC_W-1:0]         r_acc;

  assign w_prod     = a * b;
  assign w_prod_ext = {{(ACC_W-COEF_W-DATA_W){w_prod[COEF_W+DATA_W-1]}}, w_prod};
  assign acc        = r_acc;

  // Accumulate one product per enabled cycle; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

endmodule

// File: rtl/iir_biquad.sv
// Direct Form I biquad: one sample per 7 cycles through a shared MAC,
// double-buffered coefficients, rounded and saturated registered output.
module iir_biquad
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     sat,
  output logic                     overrun
);

  state_t r_state, w_next;
  logic [2:0] r_tap;

  coef_t r_stg     [N_TAPS];
  coef_t r_act     [N_TAPS];
  coef_t w_stg_nxt [N_TAPS];

  logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [DATA_W-1:0] r_dout;
  logic                     r_dout_valid, r_sat, r_overrun;

  logic                     w_din_ready, w_accept, w_mac_en, w_sub;
  coef_t                    w_coef;
  logic signed [DATA_W-1:0] w_data;
  logic signed [ACC_W-1:0]  w_acc;
  y_res_t                   w_res;

  assign w_accept   = din_valid && w_din_ready;
  assign w_res      = round_sat(w_acc);
  assign din_ready  = w_din_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sat        = r_sat;
  assign overrun    = r_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: wait for a sample, run five taps, emit, return.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = MAC;
      MAC:     if (r_tap == ADDR_A2) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: handshake and MAC enable.
  always_comb begin
    w_din_ready = (r_state == IDLE);
    w_mac_en    = (r_state == MAC);
  end

  // Tap operand select; feedback taps subtract.
  always_comb begin
    w_coef = '0;
    w_data = '0;
    w_sub  = 1'b0;
    case (r_tap)
      ADDR_B0: begin w_coef = r_act[0]; w_data = r_x0; end
      ADDR_B1: begin w_coef = r_act[1]; w_data = r_x1; end
      ADDR_B2: begin w_coef = r_act[2]; w_data = r_x2; end
      ADDR_A1: begin w_coef = r_act[3]; w_data = r_y1; w_sub = 1'b1; end
      ADDR_A2: begin w_coef = r_act[4]; w_data = r_y2; w_sub = 1'b1; end
      default: ;
    endcase
  end

  // Staging bank with this cycle's write folded in, so an accept that
  // coincides with a write loads the freshly written value.
  always_comb begin
    w_stg_nxt = r_stg;
    if (coef_we && (coef_addr <= ADDR_A2)) w_stg_nxt[coef_addr] = coef_wdata;
  end

  // Coefficient banks: staging follows writes, active loads on accept only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stg <= RST_BANK;
      r_act <= RST_BANK;
    end else begin
      r_stg <= w_stg_nxt;
      if (w_accept) r_act <= w_stg_nxt;
    end
  end

  // Tap counter: restarts on accept, advances through the MAC phase.
  always_ff @(posedge clk) begin
    if (!rst_n)                            r_tap <= '0;
    else if (w_accept)                     r_tap <= '0;
    else if (w_mac_en && r_tap != ADDR_A2) r_tap <= r_tap + 3'd1;
  end

  // Sample capture, output register, history shift and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x0         <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_y1         <= '0;
      r_y2         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (din_valid && !w_din_ready) r_overrun <= 1'b1;
      if (w_accept) r_x0 <= din;
      if (r_state == OUT) begin
        r_dout       <= w_res.y;
        r_sat        <= w_res.sat;
        r_dout_valid <= 1'b1;
        r_x2         <= r_x1;
        r_x1         <= r_x0;
        r_y2         <= r_y1;
        r_y1         <= w_res.y;
      end
    end
  end

  iir_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_accept),
    .en    (w_mac_en),
    .sub   (w_sub),
    .a     (w_coef),
    .b     (w_data),
    .acc   (w_acc)
  );

endmodule

// File: tb/tb_iir_biquad.sv
// Directed self-checking bench for iir_biquad.
module tb_iir_biquad;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               sat;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iir_biquad dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat        (sat),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    coef_we   = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    tick();
    coef_we = 1'b0;
  endtask

  // Offer one sample; returns after the accept edge.
  task automatic accept(input logic signed [15:0] x);
    int w;
    w = 0;
    while (!din_ready && w < 20) begin
      tick();
      w++;
    end
    din       = x;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Edges until dout_valid (counted from the accept edge), -1 on timeout.
  task automatic wait_dv(output int y, output int s, output int lat);
    lat = -1;
    y   = 0;
    s   = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dout_valid) begin
        lat = i;
        y   = int'(dout);
        s   = int'(sat);
        break;
      end
    end
  endtask

  task automatic send(input logic signed [15:0] x, output int y, output int s,
                      output int lat);
    accept(x);
    wait_dv(y, s, lat);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int y, s, lat, cnt;
    int exp2 [4];
    int exp3 [5];
    int acc_cyc [4];
    int n_acc;

    din        = '0;
    din_valid  = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    rst_n      = 1'b0;
    tick(); tick(); tick();

    check("rst_dout",       int'(dout),       0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_sat",        int'(sat),        0);
    check("rst_overrun",    int'(overrun),    0);
    check("rst_din_ready",  int'(din_ready),  1);
    rst_n = 1'b1;

    // Passthrough after reset, latency 6 edges.
    send(16'sd1000, y, s, lat);
    check("pass_dout", y, 1000);
    check("pass_lat",  lat, 6);
    check("pass_sat",  s, 0);
    tick();
    check("pass_pulse_len", int'(dout_valid), 0);
    check("pass_hold",      int'(dout), 1000);

    // FIR impulse response, 0.25 on each b tap.
    do_reset();
    wr_coef(3'd0, 16'h1000);
    wr_coef(3'd1, 16'h1000);
    wr_coef(3'd2, 16'h1000);
    exp2 = '{4096, 4096, 4096, 0};
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 16'sd16384 : 16'sd0, y, s, lat);
      check($sformatf("fir_impulse_%0d", i), y, exp2[i]);
    end

    // First-order feedback a1=-0.5 with a step of 1024.
    do_reset();
    wr_coef(3'd3, 16'hE000);
    exp3 = '{1024, 1536, 1792, 1920, 1984};
    for (int i = 0; i < 5; i++) begin
      send(16'sd1024, y, s, lat);
      check($sformatf("iir_step_%0d", i), y, exp3[i]);
    end

    // Saturation at both rails, then clear of sat.
    do_reset();
    wr_coef(3'd0, 16'h7FFF);
    for (int i = 0; i < 2; i++) begin
      send(16'sd32767, y, s, lat);
      check($sformatf("sat_pos_dout_%0d", i), y, 32767);
      check($sformatf("sat_pos_flag_%0d", i), s, 1);
    end
    send(-16'sd32768, y, s, lat);
    check("sat_neg_dout", y, -32768);
    check("sat_neg_flag", s, 1);
    send(16'sd0, y, s, lat);
    check("sat_clear_dout", y, 0);
    check("sat_clear_flag", s, 0);

    // din_valid held high: one accept every 7 cycles, overrun sticky.
    do_reset();
    acc_cyc = '{-1, -1, -1, -1};
    n_acc   = 0;
    din       = 16'sd100;
    din_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (din_valid && din_ready && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      tick();
    end
    din_valid = 1'b0;
    check("stream_first_accept", acc_cyc[0], 0);
    for (int i = 1; i < 4; i++)
      check($sformatf("stream_period_%0d", i), acc_cyc[i] - acc_cyc[i-1], 7);
    check("overrun_set", int'(overrun), 1);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check("overrun_sticky", int'(overrun), 1);
    do_reset();
    check("overrun_cleared", int'(overrun), 0);

    // Coefficient write during MAC affects only the next sample.
    accept(16'sd1000);
    tick();
    tick();
    wr_coef(3'd0, 16'h2000);
    wait_dv(y, s, lat);
    check("coef_mid_old", y, 1000);
    send(16'sd1000, y, s, lat);
    check("coef_mid_new", y, 500);

    // Reset in the middle of a computation abandons the sample.
    accept(16'sd1000);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (dout_valid) cnt++;
      tick();
    end
    check("midrst_no_valid", cnt, 0);
    check("midrst_dout",     int'(dout),       0);
    check("midrst_dv",       int'(dout_valid), 0);
    check("midrst_sat",      int'(sat),        0);
    check("midrst_overrun",  int'(overrun),    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_biquad.md
IIR_BIQUAD -- requirements
Module: iir_biquad

Interface
REQ-001 SHALL have these ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have these ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have these ports: din  in  16  signed two's-complement sample from the decimation stage.
REQ-004 SHALL have these ports: din_valid  in  1  din holds a new sample.
REQ-005 SHALL have these ports: din_ready  out  1  block accepts din this cycle.
REQ-006 SHALL have these ports: coef_we  in  1  coefficient write strobe.
REQ-007 SHALL have these ports: coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
REQ-008 SHALL have these ports: coef_wdata  in  16  signed Q2.14 coefficient.
REQ-009 SHALL have these ports: dout  out  16  signed filtered sample, held between updates.
REQ-010 SHALL have these ports: dout_valid  out  1  one-cycle pulse when dout updates.
REQ-011 SHALL have these ports: sat  out  1  dout of the current pulse was clipped; valid with dout_valid.
REQ-012 SHALL have these ports: overrun  out  1  sticky flag, din_valid seen while din_ready low.

Function
REQ-013 SHALL compute Direct Form I: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
REQ-014 SHALL use one shared 16x16 signed multiplier and a 36-bit signed accumulator, one product per cycle.
REQ-015 SHALL use FSM states IDLE, MAC, OUT; IDLE->MAC on accept, MAC steps tap index 0..4 (b0,b1,b2,a1,a2), MAC->OUT after tap 4, OUT->IDLE unconditionally.
REQ-016 SHALL assert din_ready only in IDLE; accept = din_valid && din_ready.
REQ-017 SHALL clear the accumulator and latch din into x[n] on accept.
REQ-018 SHALL add products for b taps and subtract products for a taps.
REQ-019 SHALL produce y by adding 2^13 to the accumulator, arithmetic-shifting right 14, then saturating to [-32768, 32767].
REQ-020 SHALL set sat when saturation changes the value, else clear it, updated with dout.
REQ-021 SHALL register dout and pulse dout_valid for one cycle on the 6th rising edge after the accept edge.
REQ-022 SHALL reassert din_ready in that same cycle, so the minimum sample period is 7 cycles.
REQ-023 SHALL on the OUT edge shift history x[n-2]<=x[n-1], x[n-1]<=x[n], y[n-2]<=y[n-1], y[n-1]<=saturated y.
REQ-024 SHALL write coefficients into a staging bank on any cycle with coef_we, regardless of FSM state.
REQ-025 SHALL copy staging to the active bank only on the accept edge.
REQ-026 SHALL never change the active bank mid-computation.
REQ-027 SHALL, when an accept and a coef_we coincide, copy the staging value with the new write applied.
REQ-028 SHALL set overrun when din_valid=1 and din_ready=0, and clear it only by reset; such samples are dropped.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, force FSM=IDLE and clear accumulator, x/y history, dout, dout_valid, sat and overrun.
REQ-030 SHALL set both coefficient banks on reset to b0=0x4000 and all others 0, giving passthrough.
REQ-031 SHALL, on reset mid-computation, abandon the sample with no dout_valid pulse.

Structure
REQ-032 SHALL place COEF_W=16, FRAC=14, ACC_W=36, the coef_addr encodings and the FSM state enum in shared package iir_pkg.
REQ-033 SHALL implement the multiplier plus accumulator as one sub-module, iir_mac, with inputs clear, en, sub, a, b and output acc.

Verification
REQ-034 SHALL verify: after reset, din=1000 with din_valid -> dout=1000, dout_valid exactly 6 edges after accept, sat=0.
REQ-035 SHALL verify: b0=b1=b2=0x1000 (0.25), a=0, impulse din=16384 then zeros -> dout 4096, 4096, 4096, 0.
REQ-036 SHALL verify: b0=0x4000, a1=0xE000 (-0.5), step din=1024 -> dout 1024, 1536, 1792, converging toward 2048.
REQ-037 SHALL verify: b0=0x7FFF, din=32767 twice -> dout=32767 with sat=1; din=-32768 -> dout=-32768 with sat=1.
REQ-038 SHALL verify: din_valid held high continuously -> accepts exactly every 7 cycles and overrun=1; overrun clears only after rst_n pulse.
REQ-039 SHALL verify: coef_we b0=0x2000 during MAC -> current output uses old b0, next sample uses 0.5 gain; rst_n=0 mid-MAC -> no dout_valid, all outputs 0.
